// File: rtl/sdram_port_mux.sv
// sdram_port_mux: shares one SDRAM access port between the RAM eraser, the
// ROM/image downloader and the CPU. Fixed priority is eraser > downloader > CPU.
// Arbitration happens once per ena slot.
// Ports:
//   clk, reset_n         clock and synchronous active-low reset
//   ena                  slot enable; sdram_*/owner/cpu_dout update only when it is high
//   er_*                 eraser stream (erasing, wr, addr, data)
//   dn_*                 downloader stream (busy, wr, addr, data)
//   cpu_*                CPU bus: wr/rd strobes, addr, din, dout, wait
//   sdram_q              SDRAM read data, valid one ena slot after sdram_rd
//   sdram_wr/rd/addr/din registered SDRAM command outputs
//   owner                slot owner: 0 idle, 1 eraser, 2 downloader, 3 CPU
module sdram_port_mux #(
  parameter logic [24:0] ROM_END = 25'h0003FFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ena,
  input  logic        er_erasing,
  input  logic        er_wr,
  input  logic [24:0] er_addr,
  input  logic [7:0]  er_data,
  input  logic        dn_busy,
  input  logic        dn_wr,
  input  logic [24:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_wait,
  input  logic [7:0]  sdram_q,
  output logic        sdram_wr,
  output logic        sdram_rd,
  output logic [24:0] sdram_addr,
  output logic [7:0]  sdram_din,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    OwnIdle   = 2'd0,
    OwnEraser = 2'd1,
    OwnDnld   = 2'd2,
    OwnCpu    = 2'd3
  } owner_e;

  logic        cpu_wr_prev_q, cpu_wr_prev_d;
  logic        pend_q, pend_d;
  logic [24:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        rdpend_q, rdpend_d;
  logic        rd_done_q, rd_done_d;
  logic        sdram_wr_q, sdram_wr_d;
  logic        sdram_rd_q, sdram_rd_d;
  logic [24:0] sdram_addr_q, sdram_addr_d;
  logic [7:0]  sdram_din_q, sdram_din_d;
  owner_e      owner_q, owner_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic        wr_rise;

  assign wr_rise = cpu_wr & ~cpu_wr_prev_q;

  always_comb begin
    cpu_wr_prev_d = cpu_wr;
    pend_d        = pend_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    rdpend_d      = rdpend_q;
    rd_done_d     = rd_done_q;
    sdram_wr_d    = sdram_wr_q;
    sdram_rd_d    = sdram_rd_q;
    sdram_addr_d  = sdram_addr_q;
    sdram_din_d   = sdram_din_q;
    owner_d       = owner_q;
    cpu_dout_d    = cpu_dout_q;

    // Write capture runs every clk so a short strobe between slots is not lost.
    if (wr_rise && !pend_q) begin
      pend_d      = 1'b1;
      pend_addr_d = cpu_addr;
      pend_data_d = cpu_din;
    end

    // Done flag keeps a still-held cpu_rd from reissuing the same read.
    if (!cpu_rd) rd_done_d = 1'b0;

    if (ena) begin
      sdram_wr_d = 1'b0;
      sdram_rd_d = 1'b0;

      if (rdpend_q) begin
        cpu_dout_d = sdram_q;
        rdpend_d   = 1'b0;
        if (cpu_rd) rd_done_d = 1'b1;
      end

      if (er_erasing) begin
        owner_d      = OwnEraser;
        sdram_wr_d   = er_wr;
        sdram_addr_d = er_addr;
        sdram_din_d  = er_data;
      end else if (dn_busy) begin
        owner_d      = OwnDnld;
        sdram_wr_d   = dn_wr;
        sdram_addr_d = dn_addr;
        sdram_din_d  = dn_data;
      end else if (pend_q) begin
        // ROM-range CPU writes still consume the slot but never reach SDRAM.
        owner_d      = OwnCpu;
        sdram_wr_d   = (pend_addr_q > ROM_END);
        sdram_addr_d = pend_addr_q;
        sdram_din_d  = pend_data_q;
        pend_d       = 1'b0;
      end else if (cpu_rd && !rdpend_q && !rd_done_q) begin
        owner_d      = OwnCpu;
        sdram_rd_d   = 1'b1;
        sdram_addr_d = cpu_addr;
        rdpend_d     = 1'b1;
      end else begin
        owner_d = OwnIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_wr_prev_q <= 1'b0;
      pend_q        <= 1'b0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
      rdpend_q      <= 1'b0;
      rd_done_q     <= 1'b0;
      sdram_wr_q    <= 1'b0;
      sdram_rd_q    <= 1'b0;
      sdram_addr_q  <= '0;
      sdram_din_q   <= '0;
      owner_q       <= OwnIdle;
      cpu_dout_q    <= 8'hFF;
    end else begin
      cpu_wr_prev_q <= cpu_wr_prev_d;
      pend_q        <= pend_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
      rdpend_q      <= rdpend_d;
      rd_done_q     <= rd_done_d;
      sdram_wr_q    <= sdram_wr_d;
      sdram_rd_q    <= sdram_rd_d;
      sdram_addr_q  <= sdram_addr_d;
      sdram_din_q   <= sdram_din_d;
      owner_q       <= owner_d;
      cpu_dout_q    <= cpu_dout_d;
    end
  end

  assign cpu_wait   = pend_q | wr_rise | (cpu_rd & ~rd_done_q);
  assign cpu_dout   = cpu_dout_q;
  assign sdram_wr   = sdram_wr_q;
  assign sdram_rd   = sdram_rd_q;
  assign sdram_addr = sdram_addr_q;
  assign sdram_din  = sdram_din_q;
  assign owner      = owner_q;

endmodule

// File: tb/tb_sdram_port_mux.sv
module tb_sdram_port_mux;

  logic        clk = 1'b0;
  logic        reset_n, ena;
  logic        er_erasing, er_wr;
  logic [24:0] er_addr;
  logic [7:0]  er_data;
  logic        dn_busy, dn_wr;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic        cpu_wr, cpu_rd;
  logic [24:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_wait;
  logic [7:0]  sdram_q;
  logic        sdram_wr, sdram_rd;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_din;
  logic [1:0]  owner;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sdram_port_mux dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ena        (ena),
    .er_erasing (er_erasing),
    .er_wr      (er_wr),
    .er_addr    (er_addr),
    .er_data    (er_data),
    .dn_busy    (dn_busy),
    .dn_wr      (dn_wr),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_wait   (cpu_wait),
    .sdram_q    (sdram_q),
    .sdram_wr   (sdram_wr),
    .sdram_rd   (sdram_rd),
    .sdram_addr (sdram_addr),
    .sdram_din  (sdram_din),
    .owner      (owner)
  );

  // Advance past the next rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ena = 1'b1;
    er_erasing = 1'b1; er_wr = 1'b0; er_addr = 25'h4000; er_data = 8'hFF;
    dn_busy = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = '0; cpu_din = '0; sdram_q = '0;
    repeat (3) tick();
    total++;
    if ({sdram_wr, sdram_rd, sdram_addr, sdram_din, owner} !== 37'd0)
      $display("FAIL reset_sdram: got wr=%b rd=%b addr=%h din=%h owner=%0d, want all 0",
               sdram_wr, sdram_rd, sdram_addr, sdram_din, owner);
    else passed++;
    total++;
    if (cpu_dout !== 8'hFF) $display("FAIL reset_dout: got %h want ff", cpu_dout);
    else passed++;
    total++;
    if (cpu_wait !== 1'b0) $display("FAIL reset_wait: got %b want 0", cpu_wait);
    else passed++;
    reset_n = 1'b1;
    tick();
    total++;
    if (owner !== 2'd1) $display("FAIL release_owner: got %0d want 1", owner);
    else passed++;
  endtask

  task automatic test_eraser();
    for (int i = 0; i < 4; i++) begin
      er_wr = 1'b1; er_addr = 25'h4000 + 25'(i); er_data = 8'hFF;
      tick();
      total++;
      if (sdram_wr !== 1'b1 || sdram_addr !== 25'h4000 + 25'(i) || sdram_din !== 8'hFF
          || owner !== 2'd1)
        $display("FAIL eraser_%0d: got wr=%b addr=%h din=%h owner=%0d, want 1/%h/ff/1",
                 i, sdram_wr, sdram_addr, sdram_din, owner, 25'h4000 + 25'(i));
      else passed++;
    end
  endtask

  task automatic test_cpu_blocked();
    cpu_wr = 1'b1; cpu_addr = 25'h5000; cpu_din = 8'hA5;
    #1;
    total++;
    if (cpu_wait !== 1'b1) $display("FAIL blk_wait_edge: got %b want 1", cpu_wait);
    else passed++;
    tick();
    cpu_wr = 1'b0;
    tick(); tick();
    total++;
    if (cpu_wait !== 1'b1 || owner !== 2'd1)
      $display("FAIL blk_held: got wait=%b owner=%0d want 1/1", cpu_wait, owner);
    else passed++;
    er_erasing = 1'b0; er_wr = 1'b0;
    tick();
    total++;
    if (owner !== 2'd3 || sdram_wr !== 1'b1 || sdram_addr !== 25'h5000 || sdram_din !== 8'hA5)
      $display("FAIL blk_grant: got owner=%0d wr=%b addr=%h din=%h want 3/1/5000/a5",
               owner, sdram_wr, sdram_addr, sdram_din);
    else passed++;
    total++;
    if (cpu_wait !== 1'b0) $display("FAIL blk_release: got %b want 0", cpu_wait);
    else passed++;
    tick();
    total++;
    if (owner !== 2'd0 || sdram_wr !== 1'b0 || sdram_addr !== 25'h5000)
      $display("FAIL idle_hold: got owner=%0d wr=%b addr=%h want 0/0/5000",
               owner, sdram_wr, sdram_addr);
    else passed++;
  endtask

  task automatic test_rom_protect();
    // Capture happens with ena low; the grant waits for the next ena slot.
    ena = 1'b0;
    cpu_wr = 1'b1; cpu_addr = 25'h0001000; cpu_din = 8'h11;
    tick();
    cpu_wr = 1'b0;
    tick();
    total++;
    if (owner !== 2'd0 || cpu_wait !== 1'b1)
      $display("FAIL rom_noena: got owner=%0d wait=%b want 0/1", owner, cpu_wait);
    else passed++;
    ena = 1'b1;
    tick();
    total++;
    if (owner !== 2'd3 || sdram_wr !== 1'b0 || sdram_addr !== 25'h0001000 || cpu_wait !== 1'b0)
      $display("FAIL rom_drop: got owner=%0d wr=%b addr=%h wait=%b want 3/0/1000/0",
               owner, sdram_wr, sdram_addr, cpu_wait);
    else passed++;
    cpu_wr = 1'b1; cpu_addr = 25'h0004000; cpu_din = 8'h22;
    tick();
    cpu_wr = 1'b0;
    tick();
    total++;
    if (owner !== 2'd3 || sdram_wr !== 1'b1 || sdram_addr !== 25'h0004000 || sdram_din !== 8'h22)
      $display("FAIL rom_end_plus1: got owner=%0d wr=%b addr=%h din=%h want 3/1/4000/22",
               owner, sdram_wr, sdram_addr, sdram_din);
    else passed++;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_rd = 1'b1; cpu_addr = 25'h6000; sdram_q = 8'h3C;
    #1;
    total++;
    if (cpu_wait !== 1'b1) $display("FAIL rd_wait: got %b want 1", cpu_wait);
    else passed++;
    tick();
    total++;
    if (sdram_rd !== 1'b1 || sdram_addr !== 25'h6000 || owner !== 2'd3)
      $display("FAIL rd_issue: got rd=%b addr=%h owner=%0d want 1/6000/3",
               sdram_rd, sdram_addr, owner);
    else passed++;
    tick();
    total++;
    if (cpu_dout !== 8'h3C || sdram_rd !== 1'b0 || cpu_wait !== 1'b0)
      $display("FAIL rd_done: got dout=%h rd=%b wait=%b want 3c/0/0",
               cpu_dout, sdram_rd, cpu_wait);
    else passed++;
    sdram_q = 8'h00;
    tick();
    total++;
    if (sdram_rd !== 1'b0 || owner !== 2'd0 || cpu_dout !== 8'h3C)
      $display("FAIL rd_no_reissue: got rd=%b owner=%0d dout=%h want 0/0/3c",
               sdram_rd, owner, cpu_dout);
    else passed++;
    cpu_rd = 1'b0;
    tick();
    cpu_rd = 1'b1; sdram_q = 8'h5A;
    tick();
    total++;
    if (sdram_rd !== 1'b1) $display("FAIL rd_toggle_issue: got %b want 1", sdram_rd);
    else passed++;
    tick();
    total++;
    if (cpu_dout !== 8'h5A) $display("FAIL rd_second: got %h want 5a", cpu_dout);
    else passed++;
    cpu_rd = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    er_erasing = 1'b1; er_wr = 1'b1; er_addr = 25'h4010; er_data = 8'hFF;
    dn_busy = 1'b1; dn_wr = 1'b1; dn_addr = 25'h7000; dn_data = 8'h77;
    cpu_wr = 1'b1; cpu_addr = 25'h5100; cpu_din = 8'hC3;
    tick();
    cpu_wr = 1'b0;
    tick();
    total++;
    if (owner !== 2'd1 || sdram_addr !== 25'h4010)
      $display("FAIL prio_eraser: got owner=%0d addr=%h want 1/4010", owner, sdram_addr);
    else passed++;
    er_erasing = 1'b0; er_wr = 1'b0;
    tick();
    total++;
    if (owner !== 2'd2 || sdram_wr !== 1'b1 || sdram_addr !== 25'h7000 || sdram_din !== 8'h77
        || cpu_wait !== 1'b1)
      $display("FAIL prio_dnld: got owner=%0d wr=%b addr=%h din=%h wait=%b want 2/1/7000/77/1",
               owner, sdram_wr, sdram_addr, sdram_din, cpu_wait);
    else passed++;
    dn_busy = 1'b0; dn_wr = 1'b0;
    tick();
    total++;
    if (owner !== 2'd3 || sdram_wr !== 1'b1 || sdram_addr !== 25'h5100 || sdram_din !== 8'hC3
        || cpu_wait !== 1'b0)
      $display("FAIL prio_cpu: got owner=%0d wr=%b addr=%h din=%h wait=%b want 3/1/5100/c3/0",
               owner, sdram_wr, sdram_addr, sdram_din, cpu_wait);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    cpu_wr = 1'b1; cpu_addr = 25'h5200; cpu_din = 8'h99;
    tick();
    cpu_wr = 1'b0; reset_n = 1'b0;
    tick();
    total++;
    if (cpu_wait !== 1'b0 || owner !== 2'd0)
      $display("FAIL rstmid_clear: got wait=%b owner=%0d want 0/0", cpu_wait, owner);
    else passed++;
    reset_n = 1'b1;
    tick();
    total++;
    if (owner !== 2'd0 || sdram_wr !== 1'b0)
      $display("FAIL rstmid_abandon: got owner=%0d wr=%b want 0/0", owner, sdram_wr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_eraser();
    test_cpu_blocked();
    test_rom_protect();
    test_cpu_read();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sdram_port_mux.md
Name: sdram_port_mux

Overview:
- Single SDRAM access port shared by three masters: RAM eraser (cold-boot fill), ROM/image downloader, and CPU.
- Sits directly downstream of the eraser; consumes its erasing/wr/addr/data stream unchanged.
- Arbitrates once per ena slot with fixed priority. Latches CPU write strobes so no CPU write is lost while a higher-priority master owns the port. Stalls the CPU via cpu_wait.

Parameters:
- ROM_END, 25'h0003FFF, highest ROM address; CPU writes at or below this are dropped (the slot still completes), eraser and downloader writes are not.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- ena  in  1  slot enable; arbitration and all port outputs update only on clk edges with ena=1
- er_erasing  in  1  eraser busy
- er_wr  in  1  eraser write valid
- er_addr  in  25  eraser address
- er_data  in  8  eraser data
- dn_busy  in  1  download in progress
- dn_wr  in  1  download write valid, one-slot pulse
- dn_addr  in  25  download address
- dn_data  in  8  download data
- cpu_wr  in  1  CPU write strobe, level, any length
- cpu_rd  in  1  CPU read request, level
- cpu_addr  in  25  CPU address
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data
- cpu_wait  out  1  1 = CPU must hold its bus cycle
- sdram_q  in  8  SDRAM read data, valid one ena slot after sdram_rd
- sdram_wr  out  1  SDRAM write
- sdram_rd  out  1  SDRAM read
- sdram_addr  out  25  SDRAM address
- sdram_din  out  8  SDRAM write data
- owner  out  2  slot owner: 0 idle, 1 eraser, 2 downloader, 3 CPU

Behaviour:
- Reset (reset_n=0 at a clk edge, regardless of ena): sdram_wr=0, sdram_rd=0, sdram_addr=0, sdram_din=0, owner=0, cpu_dout=8'hFF, cpu_wait=0. Pending-write register, read-pending flag and edge detector are cleared. Reset mid-operation abandons any pending CPU access.
- CPU write capture runs on every clk, not only ena. A rising edge of cpu_wr with no pending write latches cpu_addr/cpu_din into the pending register and sets pend.
  - A rising edge while pend=1 is ignored. The CPU cannot produce one because cpu_wait is high.
- Arbitration happens on each ena slot. Priority, first match wins:
  - (1) er_erasing=1: owner=1. Drive sdram_wr=er_wr, sdram_addr=er_addr, sdram_din=er_data.
  - (2) dn_busy=1: owner=2. Drive sdram_wr=dn_wr, sdram_addr=dn_addr, sdram_din=dn_data.
  - (3) pend=1: owner=3. Drive sdram_wr=(pend_addr>ROM_END), pending addr/data. Clear pend.
  - (4) cpu_rd=1 and no read outstanding: owner=3. Drive sdram_rd=1, sdram_addr=cpu_addr. Set rdpend.
  - (5) else: owner=0, sdram_wr=0, sdram_rd=0. sdram_addr and sdram_din hold their previous values.
- sdram_rd is 0 in every slot where (4) is not taken.
- Read completion: on the ena slot after a read issue, latch cpu_dout<=sdram_q and clear rdpend. cpu_dout holds between reads.
- cpu_wait is combinational: (pend | cpu_wr rising-edge-this-cycle) | (cpu_rd & !read_done_flag). read_done_flag sets when cpu_dout is latched and clears when cpu_rd falls.
  - A write whose pend is cleared frees the CPU on the next clk.
- Eraser and downloader both active: eraser wins. The downloader is starved; the system never runs the two together.
- An eraser write slot in which er_erasing has already fallen is treated as not erasing. The eraser deasserts wr in that same slot, so there is no loss.
- Address width is fixed at 25 bits with no wrap. Data passes through unmodified.
- Latency: a granted access appears on sdram_* at the clk edge of its ena slot, i.e. registered with 1 ena-slot latency from the input sampled in that slot.

Test Plan:
- Reset: hold reset_n=0 for 3 clk with ena=1 and er_erasing=1 -> all outputs at reset values. Release -> owner=1 on the first ena slot.
- Eraser pass-through: er_erasing=1, er_wr=1, er_addr stepping 25'h4000..25'h4003, data 8'hFF -> four consecutive ena slots show sdram_wr=1 with the same addr/data and owner=1.
- CPU write blocked by eraser: cpu_wr pulse (addr 25'h5000, data 8'hA5) during erasing -> cpu_wait=1 until erasing drops. First free ena slot writes 25'h5000/8'hA5, owner=3, then cpu_wait=0 next clk.
- ROM protect: CPU write to 25'h0001000 -> slot owner=3 with sdram_wr=0, cpu_wait released. Write to ROM_END+1 -> sdram_wr=1.
- CPU read: cpu_rd=1, addr 25'h6000, sdram_q=8'h3C next slot -> sdram_rd=1 for exactly one slot, cpu_dout=8'h3C, cpu_wait falls. No second read issued until cpu_rd toggles.
- Priority clash: dn_busy=1 with dn_wr, er_erasing=1 and pending CPU write all in one slot -> owner=1. Drop erasing -> owner=2. Drop dn_busy -> owner=3 and the CPU write completes.
